// File: rtl/cpu_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
package cpu_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SRCB_W   = 3;
    localparam int unsigned PCSRC_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_RST        = 4'd0,
        S_FETCH      = 4'd1,
        S_FETCH_WAIT = 4'd2,
        S_DECODE     = 4'd3,
        S_MEM_ADDR   = 4'd4,
        S_MEM_READ   = 4'd5,
        S_MEM_WAIT   = 4'd6,
        S_LOAD_WB    = 4'd7,
        S_MEM_WRITE  = 4'd8,
        S_R_EXEC     = 4'd9,
        S_R_WB       = 4'd10,
        S_I_EXEC     = 4'd11,
        S_I_WB       = 4'd12,
        S_BRANCH     = 4'd13,
        S_JUMP       = 4'd14,
        S_HALT       = 4'd15
    } state_t;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_LOAD = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_INC  = 3'd4,
        ALU_NEG  = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_COMP = 3'd7
    } alu_op_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;

    localparam logic [SRCB_W-1:0] SRCB_B      = 3'd0;
    localparam logic [SRCB_W-1:0] SRCB_FOUR   = 3'd1;
    localparam logic [SRCB_W-1:0] SRCB_IMM    = 3'd2;
    localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 3'd3;

    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'd0;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'd2;

    localparam logic IORD_PC     = 1'b0;
    localparam logic IORD_ALUOUT = 1'b1;
    localparam logic SRCA_PC     = 1'b0;
    localparam logic SRCA_A      = 1'b1;

endpackage

// File: rtl/funct_decoder.sv
// Maps the R-type funct field to an ALU operation and flags unsupported codes.
module funct_decoder
    import cpu_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct,
    output alu_op_t            alu_op_c,
    output logic               legal_c
);

    // Supported R-type functions; everything else is illegal and yields LOAD.
    always_comb begin
        alu_op_c = ALU_LOAD;
        legal_c  = 1'b0;
        case (funct)
            FN_ADD: begin alu_op_c = ALU_ADD; legal_c = 1'b1; end
            FN_SUB: begin alu_op_c = ALU_SUB; legal_c = 1'b1; end
            FN_AND: begin alu_op_c = ALU_AND; legal_c = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM driving every strobe and select of the multicycle MIPS datapath.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    output logic                PCWrite,
    output logic                IorD,
    output logic                wr,
    output logic                IRWrite,
    output logic                AWrite,
    output logic                BWrite,
    output logic                AOWR,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                ALUSrcA,
    output logic [SRCB_W-1:0]   ALUSrcB,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [PCSRC_W-1:0]  PCSource,
    output logic [STATE_W-1:0]  Estado,
    output logic                instr_done,
    output logic                halted
);

    state_t  state_q;
    state_t  state_d;
    alu_op_t alu_op;
    alu_op_t r_alu_op;
    logic    r_legal;
    logic    decode_illegal;
    logic    wr_s;
    logic    reg_write_s;

    funct_decoder u_funct_decoder (
        .funct    (funct),
        .alu_op_c (r_alu_op),
        .legal_c  (r_legal)
    );

    // State register; reset overrides any in-flight instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state dispatch and per-state datapath controls.
    always_comb begin
        state_d        = state_q;
        PCWrite        = 1'b0;
        IorD           = IORD_PC;
        wr_s           = 1'b0;
        IRWrite        = 1'b0;
        AWrite         = 1'b0;
        BWrite         = 1'b0;
        AOWR           = 1'b0;
        reg_write_s    = 1'b0;
        RegDst         = 1'b0;
        MemtoReg       = 1'b0;
        ALUSrcA        = SRCA_PC;
        ALUSrcB        = SRCB_B;
        alu_op         = ALU_LOAD;
        PCSource       = PCSRC_ALU;
        instr_done     = 1'b0;
        halted         = 1'b0;
        decode_illegal = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                IorD    = IORD_PC;
                state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                IRWrite  = 1'b1;
                ALUSrcA  = SRCA_PC;
                ALUSrcB  = SRCB_FOUR;
                alu_op   = ALU_ADD;
                PCSource = PCSRC_ALU;
                PCWrite  = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut gets the branch target speculatively
                AWrite  = 1'b1;
                BWrite  = 1'b1;
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_IMM_SH;
                alu_op  = ALU_ADD;
                AOWR    = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (r_legal) state_d = S_R_EXEC;
                        else         decode_illegal = 1'b1;
                    end
                    OP_ADDI:       state_d = S_I_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default:       decode_illegal = 1'b1;
                endcase
                if (decode_illegal) begin
                    if (HALT_ON_ILLEGAL) begin
                        state_d = S_HALT;
                    end else begin
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
                    end
                end
            end
            S_MEM_ADDR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALU_ADD;
                AOWR    = 1'b1;
                state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                IorD    = IORD_ALUOUT;
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                IorD    = IORD_ALUOUT;
                state_d = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                RegDst      = 1'b0;
                MemtoReg    = 1'b1;
                reg_write_s = 1'b1;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_WRITE: begin
                IorD       = IORD_ALUOUT;
                wr_s       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_R_EXEC: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_B;
                alu_op  = r_alu_op;
                AOWR    = 1'b1;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                ALUSrcA     = SRCA_A;
                ALUSrcB     = SRCB_B;
                alu_op      = r_alu_op;
                RegDst      = 1'b1;
                MemtoReg    = 1'b0;
                reg_write_s = 1'b1;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_I_EXEC: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALU_ADD;
                AOWR    = 1'b1;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                ALUSrcA     = SRCA_A;
                ALUSrcB     = SRCB_IMM;
                alu_op      = ALU_ADD;
                RegDst      = 1'b0;
                MemtoReg    = 1'b0;
                reg_write_s = 1'b1;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = SRCB_B;
                alu_op     = ALU_SUB;
                PCSource   = PCSRC_ALUOUT;
                PCWrite    = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCSource   = PCSRC_JUMP;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_RST;
        endcase
    end

    // Architectural writes are suppressed while a reset is pending.
    assign wr       = wr_s & ~reset;
    assign RegWrite = reg_write_s & ~reset;
    assign ALUOp    = alu_op;
    assign Estado   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle state/strobe scoreboard.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw;
        logic       iord;
        logic       wr;
        logic       irw;
        logic       aw;
        logic       bw;
        logic       aowr;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       srca;
        logic [2:0] srcb;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       done;
        logic       hlt;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        ctl_t       c;
    } sb_t;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        int          len;
        logic [31:0] seq;
        bit          chk_nop;
    } vec_t;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic       PCWrite, IorD, wr, IRWrite, AWrite, BWrite, AOWR, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [2:0] ALUSrcB, ALUOp;
    logic [1:0] PCSource;
    logic [3:0] Estado;
    logic       instr_done, halted;

    logic       n_PCWrite, n_IorD, n_wr, n_IRWrite, n_AWrite, n_BWrite, n_AOWR, n_RegWrite, n_RegDst, n_MemtoReg, n_ALUSrcA;
    logic [2:0] n_ALUSrcB, n_ALUOp;
    logic [1:0] n_PCSource;
    logic [3:0] n_Estado;
    logic       n_instr_done, n_halted;

    ctl_t act, n_act;
    sb_t  sb_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWrite(PCWrite), .IorD(IorD), .wr(wr), .IRWrite(IRWrite), .AWrite(AWrite),
        .BWrite(BWrite), .AOWR(AOWR), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Estado(Estado), .instr_done(instr_done), .halted(halted)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0)) dut_nop (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWrite(n_PCWrite), .IorD(n_IorD), .wr(n_wr), .IRWrite(n_IRWrite), .AWrite(n_AWrite),
        .BWrite(n_BWrite), .AOWR(n_AOWR), .RegWrite(n_RegWrite), .RegDst(n_RegDst),
        .MemtoReg(n_MemtoReg), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp),
        .PCSource(n_PCSource), .Estado(n_Estado), .instr_done(n_instr_done), .halted(n_halted)
    );

    assign act = {PCWrite, IorD, wr, IRWrite, AWrite, BWrite, AOWR, RegWrite, RegDst,
                  MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, halted};
    assign n_act = {n_PCWrite, n_IorD, n_wr, n_IRWrite, n_AWrite, n_BWrite, n_AOWR, n_RegWrite, n_RegDst,
                    n_MemtoReg, n_ALUSrcA, n_ALUSrcB, n_ALUOp, n_PCSource, n_instr_done, n_halted};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Expected controls per state, written out from the state table.
    function automatic ctl_t exp_ctl(input logic [3:0] st, input logic [5:0] op,
                                     input logic [5:0] fn, input logic z, input bit hoi);
        ctl_t c;
        logic [2:0] r_op;
        bit legal;
        c = '0;
        r_op = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : (fn == 6'h24) ? 3'd3 : 3'd0;
        legal = (op inside {6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02}) ||
                (op == 6'h00 && (fn inside {6'h20, 6'h22, 6'h24}));
        case (st)
            4'd2:  begin c.irw = 1; c.srcb = 3'd1; c.aop = 3'd1; c.pcw = 1; end
            4'd3:  begin c.aw = 1; c.bw = 1; c.srcb = 3'd3; c.aop = 3'd1; c.aowr = 1; c.done = !legal && !hoi; end
            4'd4:  begin c.srca = 1; c.srcb = 3'd2; c.aop = 3'd1; c.aowr = 1; end
            4'd5,
            4'd6:  c.iord = 1;
            4'd7:  begin c.m2r = 1; c.rw = 1; c.done = 1; end
            4'd8:  begin c.iord = 1; c.wr = 1; c.done = 1; end
            4'd9:  begin c.srca = 1; c.aop = r_op; c.aowr = 1; end
            4'd10: begin c.srca = 1; c.aop = r_op; c.rdst = 1; c.rw = 1; c.done = 1; end
            4'd11: begin c.srca = 1; c.srcb = 3'd2; c.aop = 3'd1; c.aowr = 1; end
            4'd12: begin c.srca = 1; c.srcb = 3'd2; c.aop = 3'd1; c.rw = 1; c.done = 1; end
            4'd13: begin c.srca = 1; c.aop = 3'd2; c.pcs = 2'd1; c.done = 1;
                         c.pcw = (op == 6'h04) ? z : !z; end
            4'd14: begin c.pcs = 2'd2; c.pcw = 1; c.done = 1; end
            4'd15: c.hlt = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn, input logic z);
        sb_t e;
        e.st = st;
        e.c  = exp_ctl(st, op, fn, z, 1'b1);
        sb_q.push_back(e);
    endtask

    // Pops one expected cycle and compares it against the sampled DUT (and the NOP variant if asked).
    task automatic check_cycle(input string nm, input bit nop_too);
        sb_t e;
        if (sb_q.size() == 0) begin
            cmp({nm, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            cmp({nm, " state"}, 32'(Estado), 32'(e.st));
            cmp({nm, " ctl"}, 32'(act), 32'(e.c));
            if (nop_too) begin
                cmp({nm, " nop_state"}, 32'(n_Estado), 32'(e.st));
                cmp({nm, " nop_ctl"}, 32'(n_act), 32'(e.c));
            end
        end
    endtask

    // Called at a negedge; leaves the DUT in FETCH one cycle after release.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clock);
        reset = 1'b0;
        push(4'd0, opcode, funct, zero);
        check_cycle("reset_rst", 1'b1);
        @(negedge clock);
    endtask

    // Called at a negedge with the DUT in FETCH.
    task automatic run_vec(input vec_t v);
        opcode = v.op; funct = v.fn; zero = v.z;
        for (int i = 0; i < v.len; i++) push(v.seq[4*i +: 4], v.op, v.fn, v.z);
        for (int i = 0; i < v.len; i++) begin
            check_cycle(v.name, v.chk_nop);
            @(negedge clock);
        end
    endtask

    // Runs k cycles of an instruction, then asserts reset in state seq[k].
    task automatic abort_at(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input logic [31:0] seq, input int k);
        logic [31:0] st_k;
        opcode = op; funct = fn; zero = 1'b0;
        for (int i = 0; i < k; i++) push(seq[4*i +: 4], op, fn, 1'b0);
        for (int i = 0; i < k; i++) begin
            check_cycle(nm, 1'b1);
            @(negedge clock);
        end
        st_k = seq;
        reset = 1'b1;
        #1;
        cmp({nm, " abort_state"}, 32'(Estado), 32'(st_k[4*k +: 4]));
        cmp({nm, " abort_wr"}, 32'(wr), 32'd0);
        cmp({nm, " abort_regwrite"}, 32'(RegWrite), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        push(4'd0, op, fn, 1'b0);
        check_cycle({nm, "_rst"}, 1'b1);
        cmp({nm, " rst_wr"}, 32'(wr), 32'd0);
        @(negedge clock);
    endtask

    task automatic add_vec(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int len, input logic [31:0] seq, input bit nop);
        vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.z = z; v.len = len; v.seq = seq; v.chk_nop = nop;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec("lw",       6'h23, 6'h00, 1'b0, 7, 32'h07654321, 1'b1);
        add_vec("sw",       6'h2B, 6'h00, 1'b0, 5, 32'h00084321, 1'b1);
        add_vec("add",      6'h00, 6'h20, 1'b0, 5, 32'h000A9321, 1'b1);
        add_vec("sub",      6'h00, 6'h22, 1'b0, 5, 32'h000A9321, 1'b1);
        add_vec("and",      6'h00, 6'h24, 1'b1, 5, 32'h000A9321, 1'b1);
        add_vec("addi",     6'h08, 6'h3F, 1'b0, 5, 32'h000CB321, 1'b1);
        add_vec("beq_z1",   6'h04, 6'h00, 1'b1, 4, 32'h0000D321, 1'b1);
        add_vec("beq_z0",   6'h04, 6'h00, 1'b0, 4, 32'h0000D321, 1'b1);
        add_vec("bne_z1",   6'h05, 6'h00, 1'b1, 4, 32'h0000D321, 1'b1);
        add_vec("bne_z0",   6'h05, 6'h00, 1'b0, 4, 32'h0000D321, 1'b1);
        add_vec("j",        6'h02, 6'h00, 1'b0, 4, 32'h0000E321, 1'b1);
        add_vec("bad_funct", 6'h00, 6'h21, 1'b0, 6, 32'h00FFF321, 1'b0);

        reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        push(4'd0, opcode, funct, zero);
        check_cycle("por_rst", 1'b1);
        @(negedge clock);

        foreach (vecs[i]) run_vec(vecs[i]);
        do_reset(1);

        // Illegal opcode: HALT held for 20 cycles vs. NOP back to FETCH.
        opcode = 6'h3F; funct = 6'h00; zero = 1'b0;
        push(4'd1, opcode, funct, zero);
        push(4'd2, opcode, funct, zero);
        push(4'd3, opcode, funct, zero);
        for (int i = 0; i < 20; i++) push(4'd15, opcode, funct, zero);
        for (int i = 0; i < 23; i++) begin
            check_cycle("illegal_op", 1'b0);
            if (i == 2) cmp("nop_decode_done", 32'(n_instr_done), 32'd1);
            if (i == 3) cmp("nop_back_to_fetch", 32'(n_Estado), 32'd1);
            @(negedge clock);
        end
        do_reset(2);

        abort_at("sw_abort_memaddr", 6'h2B, 6'h00, 32'h00084321, 3);
        abort_at("sw_abort_memwrite", 6'h2B, 6'h00, 32'h00084321, 4);
        abort_at("add_abort_rwb", 6'h00, 6'h20, 32'h000A9321, 4);

        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencing FSM for the multicycle MIPS datapath. It decodes the opcode and funct fields held in the instruction register, plus the ALU zero flag. Each cycle it drives every datapath strobe and mux select: PC, memory, IR, register bank, A/B, ALUOut and the ALU operation. It replaces the ad-hoc control unit and sits beside the datapath in the top level.

## Interface
- HALT_ON_ILLEGAL, 1, 1: an unknown opcode or funct enters HALT; 0: treated as NOP, returns to FETCH.
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU result == 0.
- PCWrite  out  1  load PC.
- IorD  out  1  memory address: 0=PC, 1=ALUOut.
- wr  out  1  memory write.
- IRWrite  out  1  load IR.
- AWrite, BWrite  out  1 each  load A/B.
- AOWR  out  1  load ALUOut.
- RegWrite  out  1  register bank write.
- RegDst  out  1  write register: 0=rt, 1=rd.
- MemtoReg  out  1  write data: 0=ALU result, 1=MDR.
- ALUSrcA  out  1  0=PC, 1=A.
- ALUSrcB  out  3  0=B, 1=const 4, 2=sign-extended imm, 3=sign-extended imm<<2; values 4–7 are never driven.
- ALUOp  out  3  LOAD=0, ADD=1, SUB=2, AND=3, INC=4, NEG=5, XOR=6, COMP=7.
- PCSource  out  2  0=ALU, 1=ALUOut, 2=jump address.
- Estado  out  4  current state code.
- instr_done  out  1  high in the final state of each instruction.
- halted  out  1  high in HALT.

## Operation
- Memory has 1-cycle read latency. The address is sampled at the rising edge; MDR loads every cycle.
- Unlisted outputs in a state are 0, except ALUSrcA/ALUSrcB/ALUOp/PCSource, which hold their listed value or 0.
- RST(0): all strobes 0. Next state FETCH.
- FETCH(1): IorD=0. Next FETCH_WAIT.
- FETCH_WAIT(2): IRWrite=1; ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0, PCWrite=1. Next DECODE.
- DECODE(3): AWrite=BWrite=1; ALUSrcA=0, ALUSrcB=3, ADD, AOWR=1 (branch target). Dispatch:
  - opcode 0x00 with funct 0x20/0x22/0x24 → R_EXEC
  - 0x08 → I_EXEC
  - 0x23, 0x2B → MEM_ADDR
  - 0x04, 0x05 → BRANCH
  - 0x02 → JUMP
  - anything else → HALT, or FETCH when HALT_ON_ILLEGAL=0.
- MEM_ADDR(4): ALUSrcA=1, ALUSrcB=2, ADD, AOWR=1. Next MEM_READ (lw) or MEM_WRITE (sw).
- MEM_READ(5): IorD=1. Next MEM_WAIT(6).
- MEM_WAIT(6): IorD=1. MDR captures the read data. Next LOAD_WB.
- LOAD_WB(7): RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEM_WRITE(8): IorD=1, wr=1. Next FETCH.
- R_EXEC(9): ALUSrcA=1, ALUSrcB=0, ALUOp from funct (0x20 ADD, 0x22 SUB, 0x24 AND), AOWR=1. Next R_WB.
- R_WB(10): re-drives the R_EXEC ALU controls; RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- I_EXEC(11): ALUSrcA=1, ALUSrcB=2, ADD, AOWR=1. Next I_WB.
- I_WB(12): re-drives the I_EXEC ALU controls; RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- BRANCH(13): ALUSrcA=1, ALUSrcB=0, SUB, PCSource=1. PCWrite = zero for beq (0x04), or !zero for bne (0x05). Next FETCH.
- JUMP(14): PCSource=2, PCWrite=1. Next FETCH.
- HALT(15): all strobes 0. Stays in HALT until reset.
- instr_done is high in: LOAD_WB, MEM_WRITE, R_WB, I_WB, BRANCH, JUMP, and in DECODE when NOP-ing an illegal code.

## Timing
- Reset has priority over every transition. The state register is RST in the cycle after reset is sampled, even mid-instruction. A mid-instruction reset must not produce wr or RegWrite in that cycle.
- Reset values: Estado=0; every strobe 0; ALUSrcB=0; ALUOp=0; PCSource=0; halted=0; instr_done=0.
- Outputs are combinational from the state register, plus zero/opcode in BRANCH and funct in R states. There are no output registers.
- Latency in cycles from FETCH: beq/bne 4, j 4, R-type 5, addi 5, sw 5, lw 7.
- opcode and funct are stable from the cycle after FETCH_WAIT until the next FETCH_WAIT.
- zero is sampled only in BRANCH.

## Structure
- Shared package cpu_pkg holds:
  - the state_t enum (4 bits, codes above)
  - the alu_op_t enum
  - opcode and funct constants
  - the ALUSrcB/PCSource/IorD select constants.
- A single state register with combinational next-state and output decode.
- One sub-module, funct_decoder: combinational funct → {ALUOp, legal}.

## Test plan
- Reset held 3 cycles, then released → Estado goes 0→1→2→3; IRWrite and PCWrite high only in cycle 2.
- opcode 0x00, funct 0x22 → R_EXEC/R_WB with ALUOp=SUB, RegDst=1, RegWrite=1 in R_WB; instr_done at cycle 5.
- opcode 0x23 → states 4,5,6,7; IorD=1 in 5–6; MemtoReg=1 and RegWrite=1 in 7; total 7 cycles.
- beq with zero=1 → PCWrite=1, PCSource=1 in BRANCH. bne with zero=1 → PCWrite=0.
- opcode 0x3F: HALT_ON_ILLEGAL=1 → Estado=15 and halted=1 held for 20 cycles; HALT_ON_ILLEGAL=0 → Estado returns to 1 after DECODE.
- sw with reset asserted during MEM_ADDR → next state RST; wr never asserted.
